rom_bus_controller: RTL and testbench

- ROM-side bus controller for the 4-bit multiplexed CPU bus.
- Follows the CPU's 8-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) using sync.
- Captures the 12-bit fetch address, selects the chip when the page nibble matches CHIP_ID, and drives the two instruction nibbles back onto data.
- Tracks SRC/WRR so the CPU can write a 4-bit output port; one instance per ROM chip on the bus.

---
 rtl/rom_bus_pkg.sv | 37 +++
 rtl/rom_bus_controller_tracker.sv | 25 ++
 rtl/rom_bus_controller.sv | 109 ++++++++++
 tb/tb_rom_bus_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rom_bus_pkg.sv
// Shared definitions for the 4-bit multiplexed CPU bus: the subcycle
// encoding, the opcode nibbles snooped by ROM chips, and the two-word decode.
package rom_bus_pkg;

  typedef enum logic [2:0] {
    SC_A1 = 3'd0,
    SC_A2 = 3'd1,
    SC_A3 = 3'd2,
    SC_M1 = 3'd3,
    SC_M2 = 3'd4,
    SC_X1 = 3'd5,
    SC_X2 = 3'd6,
    SC_X3 = 3'd7
  } subcycle_t;

  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;
  localparam logic [3:0] OPR_IO      = 4'hE;
  localparam logic [3:0] OPA_WRR     = 4'h2;

  // True when the opcode is followed by an operand byte (FIM shares opr 2
  // with SRC and is told apart by opa bit 0).
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    logic two;
    two = 1'b0;
    unique case (opr)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two = 1'b1;
      OPR_FIM_SRC:                        two = (opa[0] == 1'b0);
      default:                            two = 1'b0;
    endcase
    return two;
  endfunction

endpackage

// File: rtl/rom_bus_controller_tracker.sv
// Follows the CPU instruction cycle: sync marks X3, the next clock is A1.
import rom_bus_pkg::*;

module subcycle_tracker (
  input  logic      clock,
  input  logic      reset,
  input  logic      sync,
  output logic      synced,
  output subcycle_t subcycle
);

  // Any sync pulse realigns the counter to A1; otherwise free-run and wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      synced   <= 1'b0;
      subcycle <= SC_A1;
    end else if (sync) begin
      synced   <= 1'b1;
      subcycle <= SC_A1;
    end else begin
      subcycle <= subcycle_t'(subcycle + 3'd1);
    end
  end

endmodule

// File: rtl/rom_bus_controller.sv
// ROM-side bus controller: captures the fetch address, returns the selected
// instruction byte in M1/M2, and snoops SRC/WRR to drive a 4-bit output port.
import rom_bus_pkg::*;

module rom_bus_controller #(
  parameter logic [3:0] CHIP_ID  = 4'h0,
  parameter logic [3:0] IO_RESET = 4'h0
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire  [3:0] data,
  input  logic       sync,
  input  logic       rom_cmd,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_rdata,
  output logic [3:0] io_out,
  output logic       selected
);

  logic      synced;
  subcycle_t subcycle;

  logic [3:0] drive_nib;
  logic [3:0] opr;
  logic       second_word;
  logic       pend_src;
  logic       pend_wrr;
  logic       io_sel;

  logic       chip_hit;
  logic       resync;

  subcycle_tracker u_tracker (
    .clock    (clock),
    .reset    (reset),
    .sync     (sync),
    .synced   (synced),
    .subcycle (subcycle)
  );

  // Chip select is decided from the page nibble seen during A3.
  always_comb begin
    chip_hit = (rom_cmd == 1'b0) && (data == CHIP_ID);
    resync   = synced && sync && (subcycle != SC_X3);
  end

  // Bus drive comes only from registered state, so reset releases it at once.
  assign data = selected ? drive_nib : 4'bzzzz;

  // Per-subcycle capture, drive sequencing and opcode snoop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rom_addr    <= '0;
      io_out      <= IO_RESET;
      selected    <= 1'b0;
      drive_nib   <= '0;
      opr         <= '0;
      second_word <= 1'b0;
      pend_src    <= 1'b0;
      pend_wrr    <= 1'b0;
      io_sel      <= 1'b0;
    end else if (synced) begin
      if (resync) begin
        // Misaligned sync: drop everything tied to the aborted instruction,
        // keep the port selection and port value.
        selected    <= 1'b0;
        second_word <= 1'b0;
        pend_src    <= 1'b0;
        pend_wrr    <= 1'b0;
      end else begin
        unique case (subcycle)
          SC_A1: rom_addr[3:0] <= data;
          SC_A2: rom_addr[7:4] <= data;
          SC_A3: begin
            // rom_rdata is valid here (address settled at end of A2); the
            // nibble is registered so the drive holds for the whole M1 clock.
            selected  <= chip_hit;
            drive_nib <= rom_rdata[7:4];
          end
          SC_M1: begin
            opr       <= data;
            drive_nib <= rom_rdata[3:0];
          end
          SC_M2: begin
            selected <= 1'b0;
            if (second_word) begin
              second_word <= 1'b0;
            end else begin
              second_word <= is_two_word(opr, data);
              pend_src    <= (opr == OPR_FIM_SRC) && data[0];
              pend_wrr    <= (opr == OPR_IO) && (data == OPA_WRR);
            end
          end
          SC_X1: begin
          end
          SC_X2: begin
            if (pend_src) io_sel <= (data == CHIP_ID);
            if (pend_wrr && io_sel) io_out <= data;
          end
          SC_X3: begin
            pend_src <= 1'b0;
            pend_wrr <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_bus_controller.sv
// Directed bench for rom_bus_controller: stimulus pushes per-clock expected
// values into a queue, a negedge monitor pops and compares them.
module tb_rom_bus_controller;

  localparam logic [3:0] CID = 4'h3;
  localparam logic [3:0] IOR = 4'h5;
  localparam logic [3:0] ZZ  = 4'hF;  // undriven bus reads as pulled-up

  logic       clock;
  logic       reset;
  logic       sync;
  logic       rom_cmd;
  logic [7:0] rom_rdata;
  logic [7:0] rom_addr;
  logic [3:0] io_out;
  logic       selected;
  logic       tb_en;
  logic [3:0] tb_val;
  wire  [3:0] data;

  assign data = tb_en ? tb_val : 4'bzzzz;
  pullup pu0 (data[0]);
  pullup pu1 (data[1]);
  pullup pu2 (data[2]);
  pullup pu3 (data[3]);

  rom_bus_controller #(.CHIP_ID(CID), .IO_RESET(IOR)) dut (
    .clock     (clock),
    .reset     (reset),
    .data      (data),
    .sync      (sync),
    .rom_cmd   (rom_cmd),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .io_out    (io_out),
    .selected  (selected)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    bit         cd;
    logic [3:0] d;
    bit         cs;
    logic       s;
    bit         ca;
    logic [7:0] a;
    bit         ci;
    logic [3:0] io;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input string nm, input bit cd, input logic [3:0] d,
                              input logic s, input bit ca, input logic [7:0] a,
                              input logic [3:0] io);
    exp_t e;
    e.name = nm; e.cd = cd; e.d = d; e.cs = 1'b1; e.s = s;
    e.ca = ca; e.a = a; e.ci = 1'b1; e.io = io;
    return e;
  endfunction

  // Monitor: one expectation per clock, compared mid-cycle.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.cd) begin
        checks++;
        if (data !== e.d) begin
          errors++;
          $display("FAIL %s data got %h want %h", e.name, data, e.d);
        end
      end
      if (e.cs) begin
        checks++;
        if (selected !== e.s) begin
          errors++;
          $display("FAIL %s selected got %b want %b", e.name, selected, e.s);
        end
      end
      if (e.ca) begin
        checks++;
        if (rom_addr !== e.a) begin
          errors++;
          $display("FAIL %s rom_addr got %h want %h", e.name, rom_addr, e.a);
        end
      end
      if (e.ci) begin
        checks++;
        if (io_out !== e.io) begin
          errors++;
          $display("FAIL %s io_out got %h want %h", e.name, io_out, e.io);
        end
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic tick(input logic s, input logic c, input bit drv,
                      input logic [3:0] v, input exp_t e);
    sync    = s;
    rom_cmd = c;
    tb_en   = drv;
    tb_val  = v;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // One instruction cycle A1..X3. mode 0: normal, 1: resync in X1,
  // 2: reset asserted at the start of M1 (returns after M1).
  task automatic instr(input string nm, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] a2, input logic cmd, input logic [7:0] rd,
                       input bit hit, input bit tbop, input logic [3:0] opr,
                       input logic [3:0] opa, input logic [3:0] x2,
                       input logic [7:0] addr, input logic [3:0] io_b,
                       input logic [3:0] io_a, input int mode);
    rom_rdata = rd;
    tick(1'b0, 1'b1, 1'b1, a0,  mk({nm, " A1"}, 1'b0, '0, 1'b0, 1'b0, '0, io_b));
    tick(1'b0, 1'b1, 1'b1, a1,  mk({nm, " A2"}, 1'b0, '0, 1'b0, 1'b0, '0, io_b));
    tick(1'b0, cmd,  1'b1, a2,  mk({nm, " A3"}, 1'b0, '0, 1'b0, 1'b1, addr, io_b));
    if (mode == 2) begin
      reset = 1'b0;
      tick(1'b0, 1'b1, 1'b0, '0, mk({nm, " rst_m1"}, 1'b1, ZZ, 1'b0, 1'b1, 8'h00, IOR));
      return;
    end
    tick(1'b0, 1'b1, !hit && tbop, opr,
         mk({nm, " M1"}, hit || !tbop, hit ? rd[7:4] : ZZ, hit, 1'b1, addr, io_b));
    tick(1'b0, 1'b1, !hit && tbop, opa,
         mk({nm, " M2"}, hit || !tbop, hit ? rd[3:0] : ZZ, hit, 1'b1, addr, io_b));
    if (mode == 1) begin
      tick(1'b1, 1'b1, 1'b0, '0, mk({nm, " X1_resync"}, 1'b1, ZZ, 1'b0, 1'b1, addr, io_b));
      return;
    end
    tick(1'b0, 1'b1, 1'b0, '0, mk({nm, " X1"}, 1'b1, ZZ, 1'b0, 1'b1, addr, io_b));
    tick(1'b0, 1'b1, 1'b1, x2, mk({nm, " X2"}, 1'b0, '0, 1'b0, 1'b1, addr, io_b));
    tick(1'b1, 1'b1, 1'b0, '0, mk({nm, " X3"}, 1'b1, ZZ, 1'b0, 1'b1, addr, io_a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; sync = 1'b0; rom_cmd = 1'b1; rom_rdata = 8'hD7;
    tb_en = 1'b0; tb_val = '0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++)
      tick(1'b0, 1'b1, 1'b0, '0, mk("reset", 1'b1, ZZ, 1'b0, 1'b1, 8'h00, IOR));
    reset = 1'b1;

    // No sync yet: bus activity must be ignored entirely.
    for (int i = 0; i < 10; i++)
      tick(1'b0, i[0], !i[0], 4'h3,
           mk("inert", i[0], ZZ, 1'b0, 1'b1, 8'h00, IOR));
    tick(1'b1, 1'b1, 1'b0, '0, mk("first_sync", 1'b1, ZZ, 1'b0, 1'b1, 8'h00, IOR));

    instr("fetch_hit",   4'h5, 4'hA, 4'h3, 1'b0, 8'hD7, 1, 0, 4'h0, 4'h0, 4'h0, 8'hA5, IOR, IOR, 0);
    instr("miss_page",   4'h5, 4'hA, 4'h2, 1'b0, 8'hD7, 0, 0, 4'h0, 4'h0, 4'h0, 8'hA5, IOR, IOR, 0);
    instr("miss_cmd",    4'h5, 4'hA, 4'h3, 1'b1, 8'hD7, 0, 0, 4'h0, 4'h0, 4'h0, 8'hA5, IOR, IOR, 0);
    instr("jun",         4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 0, 1, 4'h4, 4'h0, 4'h3, 8'h00, IOR, IOR, 0);
    instr("jun_operand", 4'h1, 4'h0, 4'h0, 1'b0, 8'h00, 0, 1, 4'h2, 4'h2, 4'h3, 8'h01, IOR, IOR, 0);
    instr("wrr_nosel",   4'h2, 4'h0, 4'h0, 1'b0, 8'h00, 0, 1, 4'hE, 4'h2, 4'h9, 8'h02, IOR, IOR, 0);
    instr("src3",        4'h3, 4'h0, 4'h0, 1'b0, 8'h00, 0, 1, 4'h2, 4'h1, 4'h3, 8'h03, IOR, IOR, 0);
    instr("wrr9",        4'h4, 4'h0, 4'h0, 1'b0, 8'h00, 0, 1, 4'hE, 4'h2, 4'h9, 8'h04, IOR, 4'h9, 0);
    instr("src1",        4'h5, 4'h0, 4'h0, 1'b0, 8'h00, 0, 1, 4'h2, 4'h1, 4'h1, 8'h05, 4'h9, 4'h9, 0);
    instr("wrr6",        4'h6, 4'h0, 4'h0, 1'b0, 8'h00, 0, 1, 4'hE, 4'h2, 4'h6, 8'h06, 4'h9, 4'h9, 0);
    instr("src_own",     4'h0, 4'h1, 4'h3, 1'b0, 8'h21, 1, 0, 4'h0, 4'h0, 4'h3, 8'h10, 4'h9, 4'h9, 0);
    instr("wrr_a",       4'h7, 4'h0, 4'h0, 1'b0, 8'h00, 0, 1, 4'hE, 4'h2, 4'hA, 8'h07, 4'h9, 4'hA, 0);
    instr("wrr_resync",  4'h8, 4'h0, 4'h0, 1'b0, 8'h00, 0, 1, 4'hE, 4'h2, 4'h0, 8'h08, 4'hA, 4'hA, 1);
    instr("nop_after",   4'h9, 4'h0, 4'h0, 1'b0, 8'h00, 0, 1, 4'h0, 4'h0, 4'h7, 8'h09, 4'hA, 4'hA, 0);
    instr("rst_fetch",   4'h5, 4'hA, 4'h3, 1'b0, 8'hD7, 1, 0, 4'h0, 4'h0, 4'h0, 8'hA5, 4'hA, 4'hA, 2);

    tick(1'b0, 1'b1, 1'b0, '0, mk("rst_hold", 1'b1, ZZ, 1'b0, 1'b1, 8'h00, IOR));
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 4'h3, mk("rst_inert", 1'b0, '0, 1'b0, 1'b1, 8'h00, IOR));
    tick(1'b1, 1'b1, 1'b0, '0, mk("resync_after_rst", 1'b1, ZZ, 1'b0, 1'b1, 8'h00, IOR));
    instr("fetch_again", 4'hC, 4'h6, 4'h3, 1'b0, 8'h9B, 1, 0, 4'h0, 4'h0, 4'h0, 8'h6C, IOR, IOR, 0);

    sync = 1'b0;
    tb_en = 1'b0;
    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
